hiscore_upload: RTL and testbench
=================================

Name: hiscore_upload

Overview:
- Responder on the HPS ioctl upload path; the read-back counterpart of the ROM download writer.
- Serves HPS byte read requests from a window of Pengo work RAM (high-score table) so the menu can save NVRAM.
- Arbitrates a single shared RAM read port with the CPU and stretches HPS requests via ioctl_wait.
- Keeps a running 8-bit checksum of every byte served.

Parameters:
- RAM_AW, 11, width of the work RAM address bus.
- BASE, 11'h400, first work RAM address of the upload window.
- LEN, 64, window length in bytes (1..2^RAM_AW-BASE).
- RD_LAT, 1, RAM read latency in clk cycles from granted request to valid ram_q (1 or 2).

Ports:
- clk  in  1  system clock (clk_sys domain).
- reset  in  1  synchronous, active-high reset.
- ioctl_upload  in  1  high for the whole upload session.
- ioctl_rd  in  1  one-cycle strobe: HPS requests the byte at ioctl_addr.
- ioctl_addr  in  25  byte offset within the upload file.
- ioctl_din  out  8  byte returned to HPS; valid when ioctl_wait is low after a request.
- ioctl_wait  out  1  high while a request is outstanding.
- ram_req  out  1  request for the shared RAM read port.
- ram_gnt  in  1  port granted this cycle (CPU not accessing).
- ram_addr  out  RAM_AW  RAM read address.
- ram_q  in  8  RAM read data.
- sum  out  8  running checksum of bytes served this session.
- done  out  1  one-cycle pulse when ioctl_upload falls.

Behaviour:
- Reset values: ioctl_din=8'hFF, ioctl_wait=0, ram_req=0, ram_addr=BASE, sum=0, done=0, state IDLE.
- States: IDLE, REQ, LAT, HOLD.
- IDLE:
  - ioctl_rd with ioctl_upload=1 and ioctl_addr<LEN: latch ram_addr=BASE+ioctl_addr[RAM_AW-1:0], set ioctl_wait=1 in the next cycle, go to REQ.
  - ioctl_rd with ioctl_addr>=LEN: ioctl_din=8'hFF on the next cycle, ioctl_wait stays 0, sum unchanged, no RAM access.
  - ioctl_rd with ioctl_upload=0: ignored.
- REQ: ram_req=1, held until a cycle with ram_gnt=1; then drop ram_req and go to LAT with counter=RD_LAT-1.
- LAT: count down. When the counter reaches 0, capture ram_q into ioctl_din, add it to sum modulo 256, clear ioctl_wait, go to HOLD.
- Minimum request-to-wait-low latency is RD_LAT+2 cycles, reached when ram_gnt is already high.
- HOLD: ioctl_din stays stable until the next accepted request. Go to IDLE in the same cycle, so back-to-back requests are accepted one cycle after wait falls.
- ioctl_rd while ioctl_wait=1: protocol violation. Ignore it; the outstanding request completes unchanged.
- ioctl_upload rising edge: sum cleared to 0.
- ioctl_upload falling edge:
  - done pulses 1 cycle; sum holds its final value until the next session.
  - Any outstanding request is aborted, state goes to IDLE, and ram_req and ioctl_wait are cleared the next cycle.
- reset mid-request: all outputs return to reset values on the next cycle, and no further RAM access occurs.
- Address arithmetic: the BASE+offset sum is RAM_AW wide; the LEN check guarantees no wrap.

Decomposition:
- Shared package pengo_nvram_pkg holds:
  - state enum (IDLE, REQ, LAT, HOLD);
  - HISCORE_BASE and HISCORE_LEN constants, reused by a later download/restore block;
  - FILL_BYTE=8'hFF.
- No sub-module; the latency counter and checksum stay inline.

Test Plan:
- RAM[0x400..0x43F]=i, RD_LAT=1, ram_gnt tied 1, sequential reads of addr 0..63 -> each ioctl_din=addr, wait high exactly 3 cycles, final sum=8'hE0.
- ram_gnt low for 5 cycles after the request, addr 3 -> ram_req held 5 cycles, ioctl_din=8'h03, wait high 8 cycles.
- Read addr 64 and addr 1000 -> ioctl_din=8'hFF, ioctl_wait never asserted, ram_req never asserted, sum unchanged.
- RD_LAT=2 with RAM read model of latency 2, read addr 10 -> ioctl_din=8'h0A captured exactly 2 cycles after grant.
- Drop ioctl_upload while in REQ -> done pulses once, ram_req and ioctl_wait low next cycle. New session rising edge -> sum=0.
- Assert reset during LAT -> next cycle ioctl_din=8'hFF, wait=0, ram_req=0, sum=0. A following read of addr 5 -> 8'h05.

Source files
------------

// File: rtl/pengo_nvram_pkg.sv
// Shared definitions for the Pengo NVRAM (high-score) upload/restore path.
package pengo_nvram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        LAT  = 2'd2,
        HOLD = 2'd3
    } nvram_state_e;

    localparam logic [10:0] HISCORE_BASE = 11'h400;
    localparam int          HISCORE_LEN  = 64;
    localparam logic [7:0]  FILL_BYTE    = 8'hFF;

endpackage

// File: rtl/hiscore_upload.sv
// Serves HPS ioctl upload reads from the high-score window of work RAM,
// sharing the RAM read port with the CPU and keeping a running checksum.
module hiscore_upload
    import pengo_nvram_pkg::*;
#(
    parameter int              RAM_AW = 11,
    parameter logic [RAM_AW-1:0] BASE = HISCORE_BASE,
    parameter int              LEN    = HISCORE_LEN,
    parameter int              RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              ram_req,
    input  logic              ram_gnt,
    output logic [RAM_AW-1:0] ram_addr,
    input  logic [7:0]        ram_q,
    output logic [7:0]        sum,
    output logic              done
);

    nvram_state_e      r_state, w_state_nxt;
    logic [1:0]        r_cnt, w_cnt_nxt;
    logic [7:0]        r_din, w_din_nxt;
    logic              r_wait, w_wait_nxt;
    logic              r_req, w_req_nxt;
    logic [RAM_AW-1:0] r_addr, w_addr_nxt;
    logic [7:0]        r_sum, w_sum_nxt;
    logic              r_done, w_done_nxt;
    logic              r_upl_d;
    logic              w_rise, w_fall, w_in_win;

    assign w_rise   = ioctl_upload & ~r_upl_d;
    assign w_fall   = ~ioctl_upload & r_upl_d;
    assign w_in_win = (ioctl_addr < 25'(LEN));

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_din_nxt   = r_din;
        w_wait_nxt  = r_wait;
        w_req_nxt   = r_req;
        w_addr_nxt  = r_addr;
        w_sum_nxt   = r_sum;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE, HOLD: begin
                // HOLD behaves as IDLE so a new request is taken right after wait falls
                w_state_nxt = IDLE;
                if (ioctl_rd && ioctl_upload) begin
                    if (w_in_win) begin
                        w_addr_nxt  = BASE + ioctl_addr[RAM_AW-1:0];
                        w_wait_nxt  = 1'b1;
                        w_state_nxt = REQ;
                    end else begin
                        w_din_nxt = FILL_BYTE;
                    end
                end else begin
                    w_din_nxt = r_din;
                end
            end
            REQ: begin
                if (r_req && ram_gnt) begin
                    w_req_nxt   = 1'b0;
                    w_cnt_nxt   = 2'(RD_LAT - 1);
                    w_state_nxt = LAT;
                end else begin
                    w_req_nxt = 1'b1;
                end
            end
            LAT: begin
                if (r_cnt == 2'd0) begin
                    w_din_nxt   = ram_q;
                    w_sum_nxt   = r_sum + ram_q;
                    w_wait_nxt  = 1'b0;
                    w_state_nxt = HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - 2'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (w_fall) begin
            w_state_nxt = IDLE;
            w_req_nxt   = 1'b0;
            w_wait_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
        end else begin
            w_done_nxt = 1'b0;
        end
        if (w_rise) begin
            w_sum_nxt = 8'h00;
        end else begin
            w_sum_nxt = w_sum_nxt;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered outputs, latency counter and upload edge detector
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= 2'd0;
            r_din   <= FILL_BYTE;
            r_wait  <= 1'b0;
            r_req   <= 1'b0;
            r_addr  <= BASE;
            r_sum   <= 8'h00;
            r_done  <= 1'b0;
            r_upl_d <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_din   <= w_din_nxt;
            r_wait  <= w_wait_nxt;
            r_req   <= w_req_nxt;
            r_addr  <= w_addr_nxt;
            r_sum   <= w_sum_nxt;
            r_done  <= w_done_nxt;
            r_upl_d <= ioctl_upload;
        end
    end

    assign ioctl_din  = r_din;
    assign ioctl_wait = r_wait;
    assign ram_req    = r_req;
    assign ram_addr   = r_addr;
    assign sum        = r_sum;
    assign done       = r_done;

endmodule

// File: tb/tb_hiscore_upload.sv
// Directed bench for hiscore_upload: one instance with RD_LAT=1, one with RD_LAT=2.
module tb_hiscore_upload;

    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_upload;
    logic        rd1, rd2;
    logic [24:0] ioctl_addr;
    logic        ram_gnt;

    logic [7:0]  din1, din2, sum1, sum2, ram_q1, ram_q2, stage2;
    logic        wait1, wait2, req1, req2, done1, done2;
    logic [10:0] addr1, addr2;

    logic [7:0]  mem [0:2047];
    bit          sel_r;
    logic        s_wait, s_req;
    logic [7:0]  s_din;
    int          nvec = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    hiscore_upload #(.RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_rd(rd1),
        .ioctl_addr(ioctl_addr), .ioctl_din(din1), .ioctl_wait(wait1),
        .ram_req(req1), .ram_gnt(ram_gnt), .ram_addr(addr1), .ram_q(ram_q1),
        .sum(sum1), .done(done1)
    );

    hiscore_upload #(.RD_LAT(2)) dut2 (
        .clk(clk), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_rd(rd2),
        .ioctl_addr(ioctl_addr), .ioctl_din(din2), .ioctl_wait(wait2),
        .ram_req(req2), .ram_gnt(ram_gnt), .ram_addr(addr2), .ram_q(ram_q2),
        .sum(sum2), .done(done2)
    );

    // Work RAM models: one-cycle and two-cycle read latency from a granted request
    always @(posedge clk) begin
        if (req1 && ram_gnt) ram_q1 <= mem[addr1];
        if (req2 && ram_gnt) stage2 <= mem[addr2];
        ram_q2 <= stage2;
    end

    assign s_wait = sel_r ? wait2 : wait1;
    assign s_req  = sel_r ? req2  : req1;
    assign s_din  = sel_r ? din2  : din1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // In-window read; the grant is withheld for 'deny' cycles of ram_req
    task automatic read_in(input bit sel, input int a, input int deny,
                           input logic [7:0] exp_din, input int exp_wait);
        int nw, nreq, nden;
        bit rel;
        sel_r      = sel;
        ram_gnt    = (deny == 0);
        ioctl_addr = 25'(a);
        if (sel) rd2 = 1'b1; else rd1 = 1'b1;
        step();
        rd1 = 1'b0;
        rd2 = 1'b0;
        nw = 0; nreq = 0; nden = 0;
        while (s_wait && nw < 60) begin
            nw++;
            rel = 1'b0;
            if (s_req) begin
                nreq++;
                if (!ram_gnt) begin
                    nden++;
                    rel = (nden == deny);
                end
            end
            step();
            if (rel) ram_gnt = 1'b1;
        end
        ram_gnt = 1'b1;
        chk($sformatf("din_addr%0d", a), 32'(s_din), 32'(exp_din));
        chk($sformatf("wait_cycles_addr%0d", a), 32'(nw), 32'(exp_wait));
        if (deny > 0) begin
            chk("denied_req_cycles", 32'(nden), 32'(deny));
            chk("req_cycles", 32'(nreq), 32'(deny + 1));
        end
    endtask

    // Out-of-window read on dut1: fill byte, no wait, no RAM request
    task automatic read_out(input int a, input logic [7:0] exp_sum);
        int nw, nreq;
        sel_r      = 1'b0;
        ioctl_addr = 25'(a);
        rd1        = 1'b1;
        step();
        rd1 = 1'b0;
        chk($sformatf("fill_din_addr%0d", a), 32'(din1), 32'h0000_00FF);
        nw = 0; nreq = 0;
        for (int k = 0; k < 4; k++) begin
            if (wait1) nw++;
            if (req1) nreq++;
            step();
        end
        chk($sformatf("fill_wait_addr%0d", a), 32'(nw), 32'd0);
        chk($sformatf("fill_req_addr%0d", a), 32'(nreq), 32'd0);
        chk($sformatf("fill_sum_addr%0d", a), 32'(sum1), 32'(exp_sum));
    endtask

    initial begin
        for (int i = 0; i < 2048; i++)
            mem[i] = (i >= 1024 && i < 1088) ? 8'(i - 1024) : 8'(i * 3 + 1);
        reset = 1'b1; ioctl_upload = 1'b0; rd1 = 1'b0; rd2 = 1'b0;
        ioctl_addr = 25'd0; ram_gnt = 1'b1; sel_r = 1'b0;
        stage2 = 8'h00; ram_q2 = 8'h00; ram_q1 = 8'h00;
        step(); step(); step();
        chk("rst_din", 32'(din1), 32'h0000_00FF);
        chk("rst_wait", 32'(wait1), 32'd0);
        chk("rst_req", 32'(req1), 32'd0);
        chk("rst_addr", 32'(addr1), 32'h0000_0400);
        chk("rst_sum", 32'(sum1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        reset = 1'b0;
        ioctl_upload = 1'b1;
        step();

        // Sequential dump of the whole window, grant always available
        for (int a = 0; a < 64; a++) read_in(1'b0, a, 0, 8'(a), 3);
        chk("sum_full_window", 32'(sum1), 32'h0000_00E0);

        // CPU holds the port for 5 cycles of the request
        read_in(1'b0, 3, 5, 8'h03, 8);
        chk("sum_after_denied", 32'(sum1), 32'h0000_00E3);

        read_out(64, 8'hE3);
        read_out(1000, 8'hE3);

        // Two-cycle RAM latency instance
        read_in(1'b1, 7, 0, 8'h07, 4);
        read_in(1'b1, 10, 0, 8'h0A, 4);
        chk("sum_rdlat2", 32'(sum2), 32'h0000_0011);

        // Abort while in REQ
        sel_r = 1'b0;
        ram_gnt = 1'b0;
        ioctl_addr = 25'd2;
        rd1 = 1'b1;
        step();
        rd1 = 1'b0;
        chk("abort_wait_set", 32'(wait1), 32'd1);
        step();
        chk("abort_req_set", 32'(req1), 32'd1);
        ioctl_upload = 1'b0;
        step();
        chk("abort_done", 32'(done1), 32'd1);
        chk("abort_req_clr", 32'(req1), 32'd0);
        chk("abort_wait_clr", 32'(wait1), 32'd0);
        chk("abort_sum_hold", 32'(sum1), 32'h0000_00E3);
        step();
        chk("done_single_pulse", 32'(done1), 32'd0);
        ram_gnt = 1'b1;
        ioctl_upload = 1'b1;
        step();
        chk("new_session_sum", 32'(sum1), 32'd0);

        read_in(1'b0, 9, 0, 8'h09, 3);
        chk("sum_before_reset", 32'(sum1), 32'h0000_0009);

        // Reset during LAT
        ioctl_addr = 25'd20;
        rd1 = 1'b1;
        step();
        rd1 = 1'b0;
        step();
        step();
        chk("lat_wait_high", 32'(wait1), 32'd1);
        reset = 1'b1;
        step();
        chk("midrst_din", 32'(din1), 32'h0000_00FF);
        chk("midrst_wait", 32'(wait1), 32'd0);
        chk("midrst_req", 32'(req1), 32'd0);
        chk("midrst_sum", 32'(sum1), 32'd0);
        reset = 1'b0;
        step();
        chk("postrst_req", 32'(req1), 32'd0);
        read_in(1'b0, 5, 0, 8'h05, 3);
        chk("sum_after_reset_read", 32'(sum1), 32'h0000_0005);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
